// File: rtl/fp_mul_pkg.sv
// Shared types and helpers for the FP significand multiplier.
package fp_mul_pkg;

  // Radix-4 Booth digit selected from a 3-bit multiplier window.
  typedef enum logic [2:0] {
    ZERO,
    POS1,
    POS2,
    NEG1,
    NEG2
  } booth_digit_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    FINISH
  } state_t;

  // One Booth digit retires two multiplier bits; the multiplier is widened
  // by two zero bits so the top digit never sees a sign.
  function automatic int steps_f(input int sw);
    return (sw + 3) / 2;
  endfunction

endpackage

// File: rtl/booth_pp_sel.sv
// Radix-4 Booth recode and partial-product select (digit * Xr, sign-extended).
module booth_pp_sel
  import fp_mul_pkg::*;
#(
  parameter int sig_width = 23
) (
  input  logic [2:0]           win_i,
  input  logic [sig_width:0]   xr_i,
  output logic [sig_width+3:0] pp_o
);

  localparam int AW = sig_width + 4;

  booth_digit_t  dig;
  logic [3:0]    sel;
  logic [AW-1:0] x1, x2;

  // Window {b[i+1], b[i], b[i-1]} maps to digit -2*b[i+1] + b[i] + b[i-1].
  always_comb begin
    dig = ZERO;
    case (win_i)
      3'b001, 3'b010: dig = POS1;
      3'b011:         dig = POS2;
      3'b100:         dig = NEG2;
      3'b101, 3'b110: dig = NEG1;
      default:        dig = ZERO;
    endcase
  end

  assign x1  = {3'b000, xr_i};
  assign x2  = {2'b00, xr_i, 1'b0};
  assign sel = {dig == NEG2, dig == NEG1, dig == POS2, dig == POS1};

  // One-hot AND-OR mux; ZERO leaves every select low.
  assign pp_o = ({AW{sel[0]}} & x1)
              | ({AW{sel[1]}} & x2)
              | ({AW{sel[2]}} & (-x1))
              | ({AW{sel[3]}} & (-x2));

endmodule

// File: rtl/ksa.sv
// Kogge-Stone adder, modulo 2^W (no carry in/out).
module ksa #(
  parameter int W = 27
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] sum_o
);

  localparam int L = $clog2(W);

  // Prefix levels 0..L-1 keep generate and propagate; the last level only
  // needs the group generate, so it is built separately below.
  for (genvar l = 0; l < L; l++) begin : lvl
    logic [W-1:0] g;
    logic [W-1:0] p;
    if (l == 0) begin : g_init
      assign g = a_i & b_i;
      assign p = a_i ^ b_i;
    end else begin : g_comb
      localparam int D = 1 << (l - 1);
      assign g = lvl[l-1].g | (lvl[l-1].p & (lvl[l-1].g << D));
      assign p = lvl[l-1].p & (lvl[l-1].p << D);
    end
  end

  localparam int DF = 1 << (L - 1);
  logic [W-1:0] gf;

  assign gf    = lvl[L-1].g | (lvl[L-1].p & (lvl[L-1].g << DF));
  assign sum_o = lvl[0].p ^ (gf << 1);

endmodule

// File: rtl/mul_sigcalc.sv
// Iterative radix-4 Booth significand multiplier with normalized G/R/S output.
module mul_sigcalc
  import fp_mul_pkg::*;
#(
  parameter int sig_width = 23
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 enable,
  input  logic                 start,
  input  logic [sig_width:0]   x,
  input  logic [sig_width:0]   y,
  output logic                 busy,
  output logic                 done,
  output logic [sig_width:0]   quotient,
  output logic                 guard_bit,
  output logic                 round_bit,
  output logic                 sticky_bit,
  output logic                 count
);

  localparam int W     = sig_width + 1;
  localparam int STEPS = steps_f(sig_width);
  localparam int AW    = sig_width + 4;   // signed accumulator
  localparam int MW    = sig_width + 4;   // multiplier incl. implicit 0 below LSB
  localparam int LW    = 2 * STEPS;       // low product bits shifted out of acc
  localparam int PW    = 2 * W;
  localparam int SCW   = $clog2(STEPS + 1);

  state_t         state_q;
  logic [W-1:0]   xr_q;
  logic [MW-1:0]  mr_q;
  logic [AW-1:0]  acc_q, acc_d, pp, sum;
  logic [LW-1:0]  low_q, low_d;
  logic [SCW-1:0] step_q;
  logic           busy_q, done_q, g_q, r_q, s_q, cnt_q;
  logic [W-1:0]   quot_q;
  logic [PW-1:0]  p, pn;

  booth_pp_sel #(.sig_width(sig_width)) u_pp (
    .win_i (mr_q[2:0]),
    .xr_i  (xr_q),
    .pp_o  (pp)
  );

  ksa #(.W(AW)) u_add (
    .a_i   (acc_q),
    .b_i   (pp),
    .sum_o (sum)
  );

  // Arithmetic shift of {acc, low} by one radix-4 digit.
  assign acc_d = {{2{sum[AW-1]}}, sum[AW-1:2]};
  assign low_d = {sum[1:0], low_q[LW-1:2]};

  // Final accumulator is nonnegative and below 2^(PW-LW), so the raw product
  // is just its low bits stacked on the shifted-out bits.
  assign p  = {acc_q[PW-LW-1:0], low_q};
  assign pn = p[PW-1] ? p : {p[PW-2:0], 1'b0};

  // Control FSM plus datapath state; everything holds while enable is low.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      xr_q    <= '0;
      mr_q    <= '0;
      acc_q   <= '0;
      low_q   <= '0;
      step_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      g_q     <= 1'b0;
      r_q     <= 1'b0;
      s_q     <= 1'b0;
      cnt_q   <= 1'b0;
    end else if (enable) begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            xr_q    <= x;
            mr_q    <= {2'b00, y, 1'b0};
            acc_q   <= '0;
            low_q   <= '0;
            step_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          acc_q  <= acc_d;
          low_q  <= low_d;
          mr_q   <= {2'b00, mr_q[MW-1:2]};
          step_q <= step_q + SCW'(1);
          if (step_q == SCW'(STEPS - 1)) state_q <= FINISH;
        end
        FINISH: begin
          quot_q  <= pn[PW-1 -: W];
          g_q     <= pn[W-1];
          r_q     <= pn[W-2];
          s_q     <= |pn[W-3:0];
          cnt_q   <= p[PW-1];
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign quotient   = quot_q;
  assign guard_bit  = g_q;
  assign round_bit  = r_q;
  assign sticky_bit = s_q;
  assign count      = cnt_q;

endmodule

// File: tb/tb_mul_sigcalc.sv
// Bench for mul_sigcalc: cycle model of the handshake plus exact-product reference.
module tb_mul_sigcalc;

  localparam int SW    = 23;
  localparam int STEPS = (SW + 3) / 2;

  logic          clk = 1'b0;
  logic          resetn, enable, start;
  logic [SW:0]   x, y;
  logic          busy, done, guard_bit, round_bit, sticky_bit, count;
  logic [SW:0]   quotient;

  int n_tests = 0;
  int n_fail  = 0;

  mul_sigcalc #(.sig_width(SW)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .enable     (enable),
    .start      (start),
    .x          (x),
    .y          (y),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .guard_bit  (guard_bit),
    .round_bit  (round_bit),
    .sticky_bit (sticky_bit),
    .count      (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Exact product, normalized into {quotient, guard, round, sticky, count}.
  function automatic logic [27:0] ref_mul(input logic [23:0] a, input logic [23:0] b);
    logic [63:0] pr;
    logic        c;
    pr = 64'(a) * 64'(b);
    c  = (pr >= 64'h8000_0000_0000);
    if (!c) pr = pr * 2;
    return {pr[47:24], pr[23], pr[22], |pr[21:0], c};
  endfunction

  // Behavioural model: accept when idle, result appears STEPS+1 enabled edges later.
  logic        m_busy, m_done;
  logic [27:0] m_res;
  logic [23:0] m_x, m_y;
  int          m_left;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_res  <= '0;
      m_x    <= '0;
      m_y    <= '0;
      m_left <= 0;
    end else if (enable) begin
      m_done <= 1'b0;
      if (m_busy) begin
        if (m_left == 1) begin
          m_res  <= ref_mul(m_x, m_y);
          m_done <= 1'b1;
          m_busy <= 1'b0;
        end
        m_left <= m_left - 1;
      end else if (start) begin
        m_busy <= 1'b1;
        m_left <= STEPS + 1;
        m_x    <= x;
        m_y    <= y;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    check("cycle", 64'({busy, done, quotient, guard_bit, round_bit, sticky_bit, count}),
          64'({m_busy, m_done, m_res}));
  end

  task automatic do_op(input logic [23:0] a, input logic [23:0] b, input logic [27:0] exp,
                       input int exp_lat, input string nm);
    int cyc;
    x = a; y = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check({nm, "_lat"}, 64'(cyc), 64'(exp_lat));
    check({nm, "_res"}, 64'({quotient, guard_bit, round_bit, sticky_bit, count}), 64'(exp));
  endtask

  initial begin
    int cyc;
    resetn = 1'b1; enable = 1'b1; start = 1'b0; x = '0; y = '0;
    #3 resetn = 1'b0;
    #1 check("reset_state", 64'({busy, done, quotient, guard_bit, round_bit, sticky_bit, count}), 64'd0);
    @(negedge clk); #2 resetn = 1'b1;
    @(negedge clk);

    // Directed products, issued back-to-back on the done cycle.
    do_op(24'h800000, 24'h800000, 28'h8000000, 14, "one_x_one");
    do_op(24'hC00000, 24'hC00000, 28'h9000001, 14, "c0_x_c0");
    do_op(24'hFFFFFF, 24'hFFFFFF, 28'hFFFFFE3, 14, "max_x_max");
    do_op(24'h800001, 24'h800001, 28'h8000022, 14, "sticky_only");

    // Enable gap mid-operation plus a start with new operands while busy.
    x = 24'h800000; y = 24'h800000; start = 1'b1;
    @(negedge clk);
    start = 1'b0; cyc = 0;
    repeat (4) begin @(negedge clk); cyc++; end
    enable = 1'b0;
    repeat (5) begin @(negedge clk); cyc++; end
    enable = 1'b1;
    x = 24'hFFFFFF; y = 24'hFFFFFF; start = 1'b1;
    @(negedge clk); cyc++;
    start = 1'b0;
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("stall_lat", 64'(cyc), 64'd19);
    check("stall_res", 64'({quotient, guard_bit, round_bit, sticky_bit, count}), 64'h8000000);

    // done holds while disabled and clears on the next enabled edge.
    enable = 1'b0;
    repeat (2) @(negedge clk);
    check("done_hold", 64'(done), 64'd1);
    enable = 1'b1;
    @(negedge clk);
    check("done_clear", 64'(done), 64'd0);

    // Reset in the middle of an operation.
    x = 24'hFFFFFF; y = 24'h800001; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    #2 resetn = 1'b0;
    #1 check("midop_reset", 64'({busy, done, quotient, guard_bit, round_bit, sticky_bit, count}), 64'd0);
    @(negedge clk); #2 resetn = 1'b1;
    repeat (3) @(negedge clk);
    check("no_done_after_reset", 64'({busy, done}), 64'd0);
    do_op(24'hC00000, 24'hC00000, 28'h9000001, 14, "after_reset");

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, limit 200000 expected finish");
    $fatal(1);
  end

endmodule
